// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage
//
// Builds the execute-stage ALU controls. The decode-stage opcode and funct fields are
// decoded combinationally, and the result is loaded into the ID/EX control register.
// This stage also supports hazard stall and flush. Unsupported instructions are flagged,
// and a saturating counter records how many were captured.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   valid_d        decode-stage instruction valid
//   op_d           instruction opcode [6:0]
//   funct3_d       instruction [14:12]
//   funct7b5_d     instruction [30]
//   stall_e        hold the execute control register
//   flush_e        load a bubble into the execute control register
//   illegal_clr    clear the illegal-instruction counter
//   valid_e        execute-stage instruction valid
//   alu_control_e  ALU operation code (000 add, 001 sub, 010 unsigned A>B, 110 or, 111 and)
//   alu_src_e      1 = SrcB is the immediate, 0 = SrcB is rs2
//   swap_e         1 = execute exchanges SrcA and SrcB before the ALU
//   reg_write_e    writeback enable
//   mem_write_e    store enable
//   branch_e       conditional branch
//   branch_ne_e    branch taken on zero=0 (bne), otherwise on zero=1 (beq)
//   illegal_e      captured instruction is unsupported
//   illegal_count  saturating count of captured illegal instructions

module alu_ctrl_stage #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_d,
    input  logic [6:0]           op_d,
    input  logic [2:0]           funct3_d,
    input  logic                 funct7b5_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    input  logic                 illegal_clr,
    output logic                 valid_e,
    output logic [2:0]           alu_control_e,
    output logic                 alu_src_e,
    output logic                 swap_e,
    output logic                 reg_write_e,
    output logic                 mem_write_e,
    output logic                 branch_e,
    output logic                 branch_ne_e,
    output logic                 illegal_e,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpIalu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluGtu = 3'b010;
    localparam logic [2:0] AluOr  = 3'b110;
    localparam logic [2:0] AluAnd = 3'b111;

    typedef struct packed {
        logic       valid;
        logic [2:0] alu_control;
        logic       alu_src;
        logic       swap;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       branch_ne;
        logic       illegal;
    } ctrl_t;

    ctrl_t dec_ctrl;
    ctrl_t ctrl_d, ctrl_q;

    logic                 dec_illegal;
    logic                 capture;
    logic                 illegal_capture;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    // Decode the instruction fields. This logic does not depend on valid_d; the
    // capture mux below handles bubbles.
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        unique case (op_d)
            OpRtype: begin
                dec_ctrl.reg_write = 1'b1;
                if      (funct3_d == 3'b000 && !funct7b5_d) dec_ctrl.alu_control = AluAdd;
                else if (funct3_d == 3'b000 &&  funct7b5_d) dec_ctrl.alu_control = AluSub;
                else if (funct3_d == 3'b110 && !funct7b5_d) dec_ctrl.alu_control = AluOr;
                else if (funct3_d == 3'b111 && !funct7b5_d) dec_ctrl.alu_control = AluAnd;
                else if (funct3_d == 3'b011 && !funct7b5_d) begin
                    // sltu computes rs1 < rs2 as rs2 > rs1 on the swapped operands
                    dec_ctrl.alu_control = AluGtu;
                    dec_ctrl.swap        = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OpIalu: begin
                // funct7b5 is an immediate bit here, so it is not decoded
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                unique case (funct3_d)
                    3'b000: dec_ctrl.alu_control = AluAdd;
                    3'b110: dec_ctrl.alu_control = AluOr;
                    3'b111: dec_ctrl.alu_control = AluAnd;
                    3'b011: begin
                        dec_ctrl.alu_control = AluGtu;
                        dec_ctrl.swap        = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OpLoad: begin
                if (funct3_d == 3'b010) begin
                    dec_ctrl.alu_control = AluAdd;
                    dec_ctrl.alu_src     = 1'b1;
                    dec_ctrl.reg_write   = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OpStore: begin
                if (funct3_d == 3'b010) begin
                    dec_ctrl.alu_control = AluAdd;
                    dec_ctrl.alu_src     = 1'b1;
                    dec_ctrl.mem_write   = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OpBranch: begin
                dec_ctrl.alu_control = AluSub;
                dec_ctrl.branch      = 1'b1;
                unique case (funct3_d)
                    3'b000:  dec_ctrl.branch_ne = 1'b0;
                    3'b001:  dec_ctrl.branch_ne = 1'b1;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase

        // Illegal instructions carry no side effects; only valid and illegal stay set.
        if (dec_illegal) begin
            dec_ctrl         = '0;
            dec_ctrl.illegal = 1'b1;
        end
        dec_ctrl.valid = 1'b1;
    end

    assign capture         = !reset && !flush_e && !stall_e;
    assign illegal_capture = capture && valid_d && dec_illegal;

    // Priority below reset: flush > stall > capture.
    always_comb begin
        ctrl_d = '0;
        if (flush_e) begin
            ctrl_d = '0;
        end else if (stall_e) begin
            ctrl_d = ctrl_q;
        end else if (valid_d) begin
            ctrl_d = dec_ctrl;
        end else begin
            ctrl_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // Clearing and counting in the same cycle leaves the new capture counted.
    always_comb begin
        cnt_d = cnt_q;
        if (illegal_clr) begin
            cnt_d = illegal_capture ? CNT_WIDTH'(1) : '0;
        end else if (illegal_capture && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign valid_e       = ctrl_q.valid;
    assign alu_control_e = ctrl_q.alu_control;
    assign alu_src_e     = ctrl_q.alu_src;
    assign swap_e        = ctrl_q.swap;
    assign reg_write_e   = ctrl_q.reg_write;
    assign mem_write_e   = ctrl_q.mem_write;
    assign branch_e      = ctrl_q.branch;
    assign branch_ne_e   = ctrl_q.branch_ne;
    assign illegal_e     = ctrl_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Testbench for alu_ctrl_stage. Two instances share the same stimulus: one uses the
// default 8-bit counter and the other uses a 2-bit counter, so saturation can be checked.
// Execute controls are compared as {valid, alu[2:0], src, swap, rw, mw, br, bne, ill}.

module tb_alu_ctrl_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, valid_d, funct7b5_d, stall_e, flush_e, illegal_clr;
    logic [6:0] op_d;
    logic [2:0] funct3_d;

    logic       v8, src8, swp8, rw8, mw8, br8, bne8, ill8;
    logic [2:0] alu8;
    logic [7:0] cnt8;
    logic       v2, src2, swp2, rw2, mw2, br2, bne2, ill2;
    logic [2:0] alu2;
    logic [1:0] cnt2;

    alu_ctrl_stage dut8 (
        .clk(clk), .reset(reset), .valid_d(valid_d), .op_d(op_d), .funct3_d(funct3_d),
        .funct7b5_d(funct7b5_d), .stall_e(stall_e), .flush_e(flush_e),
        .illegal_clr(illegal_clr), .valid_e(v8), .alu_control_e(alu8), .alu_src_e(src8),
        .swap_e(swp8), .reg_write_e(rw8), .mem_write_e(mw8), .branch_e(br8),
        .branch_ne_e(bne8), .illegal_e(ill8), .illegal_count(cnt8)
    );

    alu_ctrl_stage #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .valid_d(valid_d), .op_d(op_d), .funct3_d(funct3_d),
        .funct7b5_d(funct7b5_d), .stall_e(stall_e), .flush_e(flush_e),
        .illegal_clr(illegal_clr), .valid_e(v2), .alu_control_e(alu2), .alu_src_e(src2),
        .swap_e(swp2), .reg_write_e(rw2), .mem_write_e(mw2), .branch_e(br2),
        .branch_ne_e(bne2), .illegal_e(ill2), .illegal_count(cnt2)
    );

    logic [10:0] act8, act2;
    assign act8 = {v8, alu8, src8, swp8, rw8, mw8, br8, bne8, ill8};
    assign act2 = {v2, alu2, src2, swp2, rw2, mw2, br2, bne2, ill2};

    localparam logic [10:0] BUB   = 11'b0;
    localparam logic [10:0] ILL   = 11'b1_000_0_0_0_0_0_0_1;
    localparam logic [10:0] ADD   = 11'b1_000_0_0_1_0_0_0_0;
    localparam logic [10:0] SUB   = 11'b1_001_0_0_1_0_0_0_0;
    localparam logic [10:0] ORR   = 11'b1_110_0_0_1_0_0_0_0;
    localparam logic [10:0] ANDR  = 11'b1_111_0_0_1_0_0_0_0;
    localparam logic [10:0] SLTU  = 11'b1_010_0_1_1_0_0_0_0;
    localparam logic [10:0] ADDI  = 11'b1_000_1_0_1_0_0_0_0;
    localparam logic [10:0] ORI   = 11'b1_110_1_0_1_0_0_0_0;
    localparam logic [10:0] ANDI  = 11'b1_111_1_0_1_0_0_0_0;
    localparam logic [10:0] SLTIU = 11'b1_010_1_1_1_0_0_0_0;
    localparam logic [10:0] LW    = 11'b1_000_1_0_1_0_0_0_0;
    localparam logic [10:0] SW    = 11'b1_000_1_0_0_1_0_0_0;
    localparam logic [10:0] BEQ   = 11'b1_001_0_0_0_0_1_0_0;
    localparam logic [10:0] BNE   = 11'b1_001_0_0_0_0_1_1_0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, st, fl, clr;
        logic [10:0] ctrl;
        int          c8, c2;
    } vec_t;

    function automatic vec_t mk(logic rst, logic v, logic [6:0] op, logic [2:0] f3, logic f7,
                                logic st, logic fl, logic clr, logic [10:0] ctrl,
                                int c8, int c2);
        vec_t r;
        r.rst = rst; r.v = v; r.op = op; r.f3 = f3; r.f7 = f7;
        r.st = st; r.fl = fl; r.clr = clr; r.ctrl = ctrl; r.c8 = c8; r.c2 = c2;
        return r;
    endfunction

    // Reference model: the list of supported encodings. Anything not listed is illegal.
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7_care, f7;
        logic [10:0] ctrl;
    } legal_t;

    legal_t legal[$];

    function automatic logic [10:0] ref_decode(logic [6:0] op, logic [2:0] f3, logic f7);
        foreach (legal[i])
            if (legal[i].op == op && legal[i].f3 == f3 && (!legal[i].f7_care || legal[i].f7 == f7))
                return legal[i].ctrl;
        return ILL;
    endfunction

    task automatic drive(input logic rst, input logic v, input logic [6:0] op,
                         input logic [2:0] f3, input logic f7, input logic st,
                         input logic fl, input logic clr);
        reset = rst; valid_d = v; op_d = op; funct3_d = f3; funct7b5_d = f7;
        stall_e = st; flush_e = fl; illegal_clr = clr;
    endtask

    vec_t vecs[$];

    initial begin
        logic [10:0] m_ctrl;
        int          m_c8, m_c2;
        logic [6:0]  ops [6];

        legal.push_back('{7'h33, 3'd0, 1'b1, 1'b0, ADD});
        legal.push_back('{7'h33, 3'd0, 1'b1, 1'b1, SUB});
        legal.push_back('{7'h33, 3'd6, 1'b1, 1'b0, ORR});
        legal.push_back('{7'h33, 3'd7, 1'b1, 1'b0, ANDR});
        legal.push_back('{7'h33, 3'd3, 1'b1, 1'b0, SLTU});
        legal.push_back('{7'h13, 3'd0, 1'b0, 1'b0, ADDI});
        legal.push_back('{7'h13, 3'd6, 1'b0, 1'b0, ORI});
        legal.push_back('{7'h13, 3'd7, 1'b0, 1'b0, ANDI});
        legal.push_back('{7'h13, 3'd3, 1'b0, 1'b0, SLTIU});
        legal.push_back('{7'h03, 3'd2, 1'b0, 1'b0, LW});
        legal.push_back('{7'h23, 3'd2, 1'b0, 1'b0, SW});
        legal.push_back('{7'h63, 3'd0, 1'b0, 1'b0, BEQ});
        legal.push_back('{7'h63, 3'd1, 1'b0, 1'b0, BNE});

        //                rst v  op     f3  f7 st fl clr ctrl   c8 c2
        vecs.push_back(mk(1, 0, 7'h00, 0, 0, 0, 0, 0, BUB,   0, 0));
        vecs.push_back(mk(1, 0, 7'h00, 0, 0, 0, 0, 0, BUB,   0, 0));
        vecs.push_back(mk(0, 0, 7'h00, 0, 0, 0, 0, 0, BUB,   0, 0));
        vecs.push_back(mk(0, 1, 7'h33, 0, 1, 0, 0, 0, SUB,   0, 0));
        vecs.push_back(mk(0, 1, 7'h13, 3, 1, 0, 0, 0, SLTIU, 0, 0));
        vecs.push_back(mk(0, 1, 7'h63, 1, 0, 0, 0, 0, BNE,   0, 0));
        vecs.push_back(mk(0, 1, 7'h33, 0, 0, 1, 0, 0, BNE,   0, 0));
        vecs.push_back(mk(0, 1, 7'h33, 0, 0, 1, 0, 0, BNE,   0, 0));
        vecs.push_back(mk(0, 1, 7'h33, 0, 0, 1, 0, 0, BNE,   0, 0));
        vecs.push_back(mk(0, 1, 7'h33, 0, 0, 1, 1, 0, BUB,   0, 0));
        vecs.push_back(mk(0, 1, 7'h33, 4, 0, 0, 0, 0, ILL,   1, 1));
        vecs.push_back(mk(0, 1, 7'h33, 4, 0, 1, 0, 0, ILL,   1, 1));
        vecs.push_back(mk(0, 1, 7'h33, 4, 0, 1, 0, 0, ILL,   1, 1));
        vecs.push_back(mk(0, 1, 7'h7f, 0, 0, 0, 0, 1, ILL,   1, 1));
        vecs.push_back(mk(0, 1, 7'h7f, 0, 0, 0, 0, 0, ILL,   2, 2));
        vecs.push_back(mk(0, 1, 7'h7f, 0, 0, 0, 0, 0, ILL,   3, 3));
        vecs.push_back(mk(0, 1, 7'h7f, 0, 0, 0, 0, 0, ILL,   4, 3));
        vecs.push_back(mk(0, 1, 7'h7f, 0, 0, 0, 0, 0, ILL,   5, 3));
        vecs.push_back(mk(1, 1, 7'h7f, 0, 0, 0, 0, 0, BUB,   0, 0));
        vecs.push_back(mk(0, 1, 7'h03, 2, 0, 0, 0, 0, LW,    0, 0));
        vecs.push_back(mk(0, 1, 7'h23, 2, 1, 0, 0, 0, SW,    0, 0));
        vecs.push_back(mk(0, 1, 7'h63, 0, 0, 0, 0, 0, BEQ,   0, 0));
        vecs.push_back(mk(0, 1, 7'h33, 6, 0, 0, 0, 0, ORR,   0, 0));
        vecs.push_back(mk(0, 1, 7'h13, 7, 1, 0, 0, 0, ANDI,  0, 0));
        vecs.push_back(mk(0, 1, 7'h33, 3, 1, 0, 0, 0, ILL,   1, 1));
        vecs.push_back(mk(0, 1, 7'h03, 0, 0, 0, 0, 0, ILL,   2, 2));
        vecs.push_back(mk(0, 0, 7'h7f, 0, 0, 0, 0, 0, BUB,   2, 2));
        vecs.push_back(mk(0, 0, 7'h00, 0, 0, 0, 0, 1, BUB,   0, 0));
        vecs.push_back(mk(0, 1, 7'h33, 3, 0, 0, 0, 0, SLTU,  0, 0));
        vecs.push_back(mk(0, 1, 7'h7f, 0, 0, 1, 0, 1, SLTU,  0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].op, vecs[i].f3, vecs[i].f7,
                  vecs[i].st, vecs[i].fl, vecs[i].clr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d ctrl", i), int'(act8), int'(vecs[i].ctrl));
            check($sformatf("vec%0d ctrl2", i), int'(act2), int'(vecs[i].ctrl));
            check($sformatf("vec%0d cnt8", i), int'(cnt8), vecs[i].c8);
            check($sformatf("vec%0d cnt2", i), int'(cnt2), vecs[i].c2);
        end

        // Randomised phase against the reference model. It starts from a reset cycle.
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
        ops[3] = 7'h23; ops[4] = 7'h63; ops[5] = 7'h00;
        m_ctrl = '0; m_c8 = 0; m_c2 = 0;
        for (int n = 0; n < 3000; n++) begin
            logic       r, v, f7, st, fl, clr, cap_ill;
            logic [6:0] op;
            logic [2:0] f3;
            r   = (n == 0) || ($urandom_range(0, 99) < 2);
            v   = $urandom_range(0, 3) != 0;
            st  = $urandom_range(0, 4) == 0;
            fl  = $urandom_range(0, 9) == 0;
            clr = $urandom_range(0, 19) == 0;
            op  = ops[$urandom_range(0, 5)];
            if (op == 7'h00) op = 7'($urandom);
            f3  = 3'($urandom);
            f7  = 1'($urandom);
            drive(r, v, op, f3, f7, st, fl, clr);
            @(posedge clk);
            #1;
            if (r) begin
                m_ctrl = '0; m_c8 = 0; m_c2 = 0;
            end else begin
                cap_ill = !fl && !st && v && (ref_decode(op, f3, f7) == ILL);
                if (fl)      m_ctrl = '0;
                else if (!st) m_ctrl = v ? ref_decode(op, f3, f7) : '0;
                if (clr) begin
                    m_c8 = cap_ill ? 1 : 0;
                    m_c2 = cap_ill ? 1 : 0;
                end else if (cap_ill) begin
                    m_c8 = (m_c8 + 1 > 255) ? 255 : m_c8 + 1;
                    m_c2 = (m_c2 + 1 > 3) ? 3 : m_c2 + 1;
                end
            end
            check($sformatf("rnd%0d ctrl", n), int'(act8), int'(m_ctrl));
            check($sformatf("rnd%0d ctrl2", n), int'(act2), int'(m_ctrl));
            check($sformatf("rnd%0d cnt8", n), int'(cnt8), m_c8);
            check($sformatf("rnd%0d cnt2", n), int'(cnt2), m_c2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Registered control producer for the execute-stage ALU.
- Decodes opcode/funct fields in decode and drives the 3-bit ALU operation code, operand-select and side-effect controls into execute through the ID/EX control register.
- Supports hazard stall/flush.
- Flags unsupported instructions and counts them for the trap/debug logic.

Parameters:
- CNT_WIDTH, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- valid_d  input  1  decode-stage instruction valid
- op_d  input  7  instruction opcode [6:0]
- funct3_d  input  3  instruction [14:12]
- funct7b5_d  input  1  instruction [30]
- stall_e  input  1  hold the execute control register
- flush_e  input  1  load a bubble into the execute control register
- illegal_clr  input  1  clear the illegal counter
- valid_e  output  1  execute-stage instruction valid
- alu_control_e  output  3  ALU operation code
- alu_src_e  output  1  1 = SrcB is the immediate; 0 = SrcB is rs2
- swap_e  output  1  1 = execute exchanges SrcA and SrcB before the ALU
- reg_write_e  output  1  writeback enable
- mem_write_e  output  1  store enable
- branch_e  output  1  conditional branch
- branch_ne_e  output  1  branch taken when zero=0 (bne); else when zero=1 (beq)
- illegal_e  output  1  captured instruction is unsupported
- illegal_count  output  CNT_WIDTH  saturating count of illegal instructions captured

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous, active-high.
  - On reset, every output register is 0, including alu_control_e = 3'b000 and illegal_count = 0.
- ALU op codes (fixed encoding):
  - 000 add
  - 001 sub
  - 010 unsigned A>B
  - 110 or
  - 111 and
- Latency:
  - Decode is combinational on the _d inputs.
  - Results are registered; they appear on the _e outputs one clock after capture.
- Register update priority, each cycle: reset > flush_e > stall_e > capture.
  - flush_e: load a bubble. Bubble = all _e outputs 0. flush_e wins over a simultaneous stall_e.
  - stall_e (no flush): all _e registers hold their value.
  - Capture with valid_d=0: load a bubble.
  - Capture with valid_d=1: load the decoded controls, valid_e=1.
- R-type, op 0110011: reg_write=1, alu_src=0.
  - funct3 000, f7b5=0: add.
  - funct3 000, f7b5=1: sub.
  - funct3 110, f7b5=0: or.
  - funct3 111, f7b5=0: and.
  - funct3 011 (sltu), f7b5=0: op 010 with swap=1.
  - Anything else: illegal.
- I-ALU, op 0010011: reg_write=1, alu_src=1. funct7b5 is ignored (it is an immediate bit).
  - funct3 000: add.
  - funct3 110: or.
  - funct3 111: and.
  - funct3 011 (sltiu): op 010 with swap=1.
  - Anything else: illegal.
- Load, op 0000011, funct3 010 only: add, alu_src=1, reg_write=1.
- Store, op 0100011, funct3 010 only: add, alu_src=1, mem_write=1.
- Branch, op 1100011: sub, alu_src=0, branch=1.
  - funct3 000: branch_ne=0.
  - funct3 001: branch_ne=1.
  - Other funct3: illegal.
- Any other opcode: illegal.
- Illegal capture:
  - valid_e=1, illegal_e=1.
  - alu_control_e=000; all other controls 0 (no side effects).
- illegal_count:
  - Increments by 1 only on a cycle where an illegal instruction is captured, i.e. not during stall, flush or reset.
  - Saturates at 2^CNT_WIDTH-1.
  - illegal_clr sets it to 0.
  - illegal_clr together with an illegal capture in the same cycle sets it to 1.
  - Holding an illegal instruction under stall does not recount it.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then valid_d=0 → all _e outputs 0, illegal_count=0.
- R-type sub: valid_d=1, op 0110011, funct3 000, f7b5=1 → next cycle alu_control_e=001, reg_write_e=1, alu_src_e=0, valid_e=1, illegal_e=0.
- sltiu: op 0010011, funct3 011, f7b5=1 → alu_control_e=010, swap_e=1, alu_src_e=1, reg_write_e=1.
- Branch sequence: bne (op 1100011, f3 001), then stall_e=1 for 3 cycles with a new add on the inputs → branch_ne_e=1 and alu_control_e=001 held for all 3 cycles. Then flush_e=1 together with stall_e=1 → bubble, valid_e=0.
- Illegal xor: op 0110011, funct3 100 → valid_e=1, illegal_e=1, reg_write_e=0, count 0→1. Stall it 2 cycles → count stays 1. illegal_clr together with a new illegal capture → count=1.
- Saturation: CNT_WIDTH=2 with 5 consecutive illegal captures → count reads 1,2,3,3,3. Synchronous reset mid-stream → count 0 and valid_e 0 on the next edge.
